// File: rtl/rom_vram_copier.sv
//------------------------------------------------------------------------------
// rom_vram_copier : boot-time ROM -> VRAM image copy engine, one word per ROM read
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rom_vram_copier #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 8,
  parameter int WORDS       = 16000,
  parameter int ROM_LATENCY = 1,
  parameter int AUTOSTART   = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_data,
  output logic              vram_we,
  input  logic              vram_stall,
  output logic              progress,
  output logic              done
);

  localparam int                CNT_W     = 3;
  localparam logic [CNT_W-1:0]  C_WAIT_LD = CNT_W'(ROM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] C_LAST    = ADDR_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t             state_q,     state_d;
  logic [ADDR_W-1:0]  index_q,     index_d;
  logic [ADDR_W-1:0]  rom_addr_q,  rom_addr_d;
  logic [ADDR_W-1:0]  vram_addr_q, vram_addr_d;
  logic [DATA_W-1:0]  vram_data_q, vram_data_d;
  logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
  logic               progress_q,  progress_d;
  logic               done_q,      done_d;
  logic               first_q,     first_d;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    rom_addr_d  = rom_addr_q;
    vram_addr_d = vram_addr_q;
    vram_data_d = vram_data_q;
    wait_cnt_d  = wait_cnt_q;
    progress_d  = progress_q;
    done_d      = done_q;
    first_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // first_q is only high on the first clock after reset release
        if (start || ((AUTOSTART != 0) && first_q)) begin
          index_d    = '0;
          rom_addr_d = '0;
          progress_d = 1'b1;
          done_d     = 1'b0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        wait_cnt_d = C_WAIT_LD;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          vram_data_d = rom_data;
          vram_addr_d = index_q;
          state_d     = S_WRITE;
        end else begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (!vram_stall) begin
          if (index_q == C_LAST) begin
            state_d = S_FINISH;
          end else begin
            index_d    = index_q + ADDR_W'(1);
            rom_addr_d = index_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        progress_d = 1'b0;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      index_q     <= '0;
      rom_addr_q  <= '0;
      vram_addr_q <= '0;
      vram_data_q <= '0;
      wait_cnt_q  <= '0;
      progress_q  <= 1'b0;
      done_q      <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      rom_addr_q  <= rom_addr_d;
      vram_addr_q <= vram_addr_d;
      vram_data_q <= vram_data_d;
      wait_cnt_q  <= wait_cnt_d;
      progress_q  <= progress_d;
      done_q      <= done_d;
      first_q     <= first_d;
    end
  end

  // Stall gates the strobe directly so scan-out wins the slot in the same cycle
  assign vram_we   = (state_q == S_WRITE) && !vram_stall;
  assign rom_addr  = rom_addr_q;
  assign vram_addr = vram_addr_q;
  assign vram_data = vram_data_q;
  assign progress  = progress_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_vram_copier.sv
//------------------------------------------------------------------------------
// tb_rom_vram_copier : two copier instances (L=1 autostart, L=3 manual start on a
// full 4-bit address range) checked against a transaction-level copy model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rom_vram_copier;

  localparam int WORDS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start_a, start_b, stall_a, stall_b;
  logic [13:0] rom_addr_a, vram_addr_a;
  logic [3:0]  rom_addr_b, vram_addr_b;
  logic [7:0]  rom_data_a, rom_data_b, vram_data_a, vram_data_b;
  logic        we_a, we_b, prog_a, prog_b, done_a, done_b;

  rom_vram_copier #(.ADDR_W(14), .DATA_W(8), .WORDS(WORDS), .ROM_LATENCY(1), .AUTOSTART(1)) u_dut_a (
    .clk_sys(clk), .reset_n(reset_n), .start(start_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .vram_addr(vram_addr_a), .vram_data(vram_data_a), .vram_we(we_a), .vram_stall(stall_a),
    .progress(prog_a), .done(done_a));

  rom_vram_copier #(.ADDR_W(4), .DATA_W(8), .WORDS(WORDS), .ROM_LATENCY(3), .AUTOSTART(0)) u_dut_b (
    .clk_sys(clk), .reset_n(reset_n), .start(start_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .vram_addr(vram_addr_b), .vram_data(vram_data_b), .vram_we(we_b), .vram_stall(stall_b),
    .progress(prog_b), .done(done_b));

  // ROM images; instance A has a 1-cycle ROM, instance B a 3-stage ROM pipeline
  logic [7:0] rom_img [2][WORDS];
  logic [7:0] pipe_b [3];

  always_ff @(posedge clk) rom_data_a <= rom_img[0][rom_addr_a[3:0]];
  always_ff @(posedge clk) begin
    pipe_b[0] <= rom_img[1][rom_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rom_data_b = pipe_b[2];

  // Copy model state: a copy is a list of WORDS writes; each write becomes ready
  // ROM_LATENCY+1 cycles after the copy starts, or ROM_LATENCY+2 after the previous one
  bit busy [2];
  bit prog_e [2];
  bit done_e [2];
  int widx [2];
  int ready [2];
  int fin_at [2];
  int st_cyc [2];
  int blocked [2];
  int tgt [2];
  int hold [2];
  int spct [2];
  bit auto_pend;
  bit rand_start;
  int cyc;
  int n_vec;
  int n_bad;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    bit req [2];
    bit stl [2];
    bit ewe;
    logic we_o [2];
    logic pg_o [2];
    logic dn_o [2];
    logic [31:0] ad_o [2];
    logic [31:0] da_o [2];
    req[0] = (start_a | auto_pend) & reset_n;
    req[1] = start_b & reset_n;
    @(posedge clk);
    cyc++;
    auto_pend = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      if (req[k] && !busy[k]) begin
        busy[k] = 1'b1; widx[k] = 0; ready[k] = cyc + lat(k) + 1; fin_at[k] = -1;
        prog_e[k] = 1'b1; done_e[k] = 1'b0; st_cyc[k] = cyc; blocked[k] = 0;
      end
      if (busy[k] && fin_at[k] == cyc) begin
        busy[k] = 1'b0; prog_e[k] = 1'b0; done_e[k] = 1'b1;
        chk($sformatf("duration[%0d]", k), 32'(cyc - st_cyc[k] + 1),
            32'(WORDS * (lat(k) + 2) + 2 + blocked[k]));
      end
      if (hold[k] > 0) begin
        stl[k] = 1'b1; hold[k]--;
      end else if (busy[k] && widx[k] == tgt[k] && cyc >= ready[k]) begin
        stl[k] = 1'b1; hold[k] = 4; tgt[k] = -1;
      end else begin
        stl[k] = ($urandom_range(99) < spct[k]);
      end
    end
    stall_a = stl[0];
    stall_b = stl[1];
    start_a = rand_start && busy[0] && ($urandom_range(7) == 0);
    start_b = rand_start && busy[1] && ($urandom_range(7) == 0);
    #1;
    we_o[0] = we_a; pg_o[0] = prog_a; dn_o[0] = done_a; ad_o[0] = 32'(vram_addr_a); da_o[0] = 32'(vram_data_a);
    we_o[1] = we_b; pg_o[1] = prog_b; dn_o[1] = done_b; ad_o[1] = 32'(vram_addr_b); da_o[1] = 32'(vram_data_b);
    for (int k = 0; k < 2; k++) begin
      ewe = busy[k] && (widx[k] < WORDS) && (cyc >= ready[k]);
      if (ewe && stl[k]) begin
        blocked[k]++;
        ewe = 1'b0;
      end
      chk($sformatf("vram_we[%0d]", k), 32'(we_o[k]), 32'(ewe));
      if (ewe) begin
        chk($sformatf("vram_addr[%0d]", k), ad_o[k], 32'(widx[k]));
        chk($sformatf("vram_data[%0d]", k), da_o[k], 32'(rom_img[k][widx[k]]));
        widx[k]++;
        ready[k] = cyc + lat(k) + 2;
        if (widx[k] == WORDS) fin_at[k] = cyc + 2;
      end
      chk($sformatf("progress[%0d]", k), 32'(pg_o[k]), 32'(prog_e[k]));
      chk($sformatf("done[%0d]", k), 32'(dn_o[k]), 32'(done_e[k]));
    end
  endtask

  task automatic run_idle(input int limit);
    int n;
    n = 0;
    while ((busy[0] || busy[1]) && n < limit) begin
      step();
      n++;
    end
    chk("timeout", 32'(busy[0] || busy[1]), 32'd0);
  endtask

  task automatic reset_mid();
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
    #1;
    chk("rst_rom_addr_a", 32'(rom_addr_a), 32'd0);
    chk("rst_vram_addr_a", 32'(vram_addr_a), 32'd0);
    chk("rst_vram_data_a", 32'(vram_data_a), 32'd0);
    chk("rst_we_a", 32'(we_a), 32'd0);
    chk("rst_progress_a", 32'(prog_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_rom_addr_b", 32'(rom_addr_b), 32'd0);
    chk("rst_vram_addr_b", 32'(vram_addr_b), 32'd0);
    chk("rst_vram_data_b", 32'(vram_data_b), 32'd0);
    chk("rst_we_b", 32'(we_b), 32'd0);
    chk("rst_progress_b", 32'(prog_b), 32'd0);
    chk("rst_done_b", 32'(done_b), 32'd0);
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; prog_e[k] = 1'b0; done_e[k] = 1'b0;
      fin_at[k] = -1; hold[k] = 0; tgt[k] = -1;
    end
    step();
    step();
    reset_n = 1'b1;
    auto_pend = 1'b1;
  endtask

  task automatic new_images();
    for (int i = 0; i < WORDS; i++) begin
      rom_img[0][i] = 8'($urandom);
      rom_img[1][i] = 8'($urandom);
    end
  endtask

  initial begin
    cyc = 0; n_vec = 0; n_bad = 0; auto_pend = 1'b0; rand_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      busy[k] = 1'b0; prog_e[k] = 1'b0; done_e[k] = 1'b0; widx[k] = 0; ready[k] = 0;
      fin_at[k] = -1; st_cyc[k] = 0; blocked[k] = 0; tgt[k] = -1; hold[k] = 0; spct[k] = 0;
    end
    for (int i = 0; i < WORDS; i++) begin
      rom_img[0][i] = 8'(i) ^ 8'hA5;
      rom_img[1][i] = 8'($urandom);
    end
    reset_n = 1'b1; start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
    #2;
    reset_mid();

    // Autostart copy on A, manual start on B with a second start ignored
    repeat (9) step();
    start_b = 1'b1; step();
    repeat (9) step();
    start_b = 1'b1; step();
    run_idle(300);

    // Five-cycle stall on the write of word 3 for both instances
    tgt[0] = 3; tgt[1] = 3;
    start_a = 1'b1; start_b = 1'b1; step();
    run_idle(300);

    // Start during the FINISH cycle is ignored; start after done repeats the copy
    start_b = 1'b1; step();
    for (int i = 0; i < 200 && !(busy[1] && fin_at[1] == cyc + 1); i++) step();
    start_b = 1'b1; step();
    run_idle(300);
    start_a = 1'b1; start_b = 1'b1; step();
    run_idle(300);

    // Reset in the middle of a copy, then A restarts from address 0 on its own
    new_images();
    start_a = 1'b1; start_b = 1'b1; step();
    for (int i = 0; i < 200 && widx[0] < 8; i++) step();
    reset_mid();
    step();
    run_idle(300);

    // Random images, random stall density, spurious starts while busy
    rand_start = 1'b1;
    for (int r = 0; r < 6; r++) begin
      new_images();
      spct[0] = $urandom_range(50);
      spct[1] = $urandom_range(50);
      tgt[0] = $urandom_range(WORDS - 1);
      tgt[1] = $urandom_range(WORDS - 1);
      start_a = 1'b1; start_b = 1'b1; step();
      run_idle(800);
    end
    rand_start = 1'b0;
    spct[0] = 0; spct[1] = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
